// File: rtl/fibonacci_engine_if.sv
// Handshake/result bundle for the Fibonacci engine.
//   start, n_in          : request side (master drives)
//   busy, done           : status (engine drives)
//   fib_out, fib_next    : F(n), F(n+1) modulo 2^OUT_W
//   overflow             : exact F(n) does not fit in OUT_W bits
interface fibonacci_engine_if #(
  parameter int IN_W  = 10,
  parameter int OUT_W = 16
);
  logic             start;
  logic [IN_W-1:0]  n_in;
  logic             busy;
  logic             done;
  logic [OUT_W-1:0] fib_out;
  logic [OUT_W-1:0] fib_next;
  logic             overflow;

  modport master (
    output start, n_in,
    input  busy, done, fib_out, fib_next, overflow
  );

  modport slave (
    input  start, n_in,
    output busy, done, fib_out, fib_next, overflow
  );
endinterface

// File: rtl/fibonacci_engine.sv
// Fast-doubling Fibonacci engine: returns F(n) and F(n+1) modulo 2^OUT_W
// for an IN_W-bit index, with a fixed latency of 2*IN_W+1 cycles from the
// accepting edge to done, independent of n.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active-low
//   bus  : fibonacci_engine_if.slave (start/n_in in; busy/done/results out)
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; done cleared
// DOUBLE  | d = a*(2b-a), e = a*a + b*b  (F(2m), F(2m+1))
// ADVANCE | fold in bit n_reg[idx]; step idx or finish
// FINISH  | publish a/b, set overflow, pulse done, drop busy
module fibonacci_engine #(
  parameter int IN_W     = 10,
  parameter int OUT_W    = 16,
  parameter int FIB_NMAX = 24
) (
  input logic            clk,
  input logic            rst,
  fibonacci_engine_if.slave bus
);

  localparam int IDX_W = (IN_W > 1) ? $clog2(IN_W) : 1;

  typedef enum logic [1:0] {IDLE, DOUBLE, ADVANCE, FINISH} state_t;

  state_t           state;
  logic [IN_W-1:0]  n_reg;
  logic [IDX_W-1:0] idx;
  logic [OUT_W-1:0] a, b, d, e;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      n_reg        <= '0;
      idx          <= IDX_W'(IN_W - 1);
      a            <= '0;
      b            <= OUT_W'(1);
      d            <= '0;
      e            <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.fib_out  <= '0;
      bus.fib_next <= '0;
      bus.overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            n_reg    <= bus.n_in;
            a        <= '0;
            b        <= OUT_W'(1);
            idx      <= IDX_W'(IN_W - 1);
            bus.busy <= 1'b1;
            state    <= DOUBLE;
          end
        end
        DOUBLE: begin
          // All terms stay OUT_W wide, so the subtraction wraps naturally.
          d     <= a * ((b << 1) - a);
          e     <= (a * a) + (b * b);
          state <= ADVANCE;
        end
        ADVANCE: begin
          if (n_reg[idx]) begin
            a <= e;
            b <= d + e;
          end else begin
            a <= d;
            b <= e;
          end
          if (idx == '0) begin
            state <= FINISH;
          end else begin
            idx   <= idx - 1'b1;
            state <= DOUBLE;
          end
        end
        FINISH: begin
          bus.fib_out  <= a;
          bus.fib_next <= b;
          bus.overflow <= (int'(n_reg) > FIB_NMAX);
          bus.done     <= 1'b1;
          bus.busy     <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fibonacci_engine.sv
module tb_fibonacci_engine;
  localparam int IN_W  = 10;
  localparam int OUT_W = 16;
  localparam int LAT   = 2 * IN_W + 1;
  localparam int NREF  = (1 << IN_W) + 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fibonacci_engine_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  fibonacci_engine #(.IN_W(IN_W), .OUT_W(OUT_W), .FIB_NMAX(24)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain iterative Fibonacci, modular and exact (saturated).
  logic [OUT_W-1:0] ref_f   [NREF];
  bit               ref_ovf [NREF];
  longint           ref_ex  [NREF];

  typedef struct {
    int               n;
    logic [OUT_W-1:0] f;
    logic [OUT_W-1:0] fn;
    logic             ovf;
    int               acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.done) begin
        chk("done_width", 64'(prev_done), 64'd0);
        chk("busy_at_done", 64'(bus.busy), 64'd0);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
        end else begin
          mon_e = sb.pop_front();
          chk($sformatf("fib_out(n=%0d)", mon_e.n), 64'(bus.fib_out), 64'(mon_e.f));
          chk($sformatf("fib_next(n=%0d)", mon_e.n), 64'(bus.fib_next), 64'(mon_e.fn));
          chk($sformatf("overflow(n=%0d)", mon_e.n), 64'(bus.overflow), 64'(mon_e.ovf));
          chk($sformatf("latency(n=%0d)", mon_e.n), 64'(cyc - mon_e.acc), 64'(LAT));
        end
      end else if (sb.size() > 0 && cyc >= sb[0].acc) begin
        chk("busy_in_flight", 64'(bus.busy), 64'd1);
      end
      prev_done = bus.done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic issue(input int n);
    int w = 0;
    @(negedge clk);
    while (bus.busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (bus.busy) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout actual=busy required=idle n=%0d", n);
      return;
    end
    bus.start = 1'b1;
    bus.n_in  = IN_W'(n);
    sb.push_back('{n, ref_f[n], ref_f[n+1], ref_ovf[n], cyc + 1});
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.n_in  = IN_W'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},     64'(bus.busy),     64'd0);
    chk({tag, "_done"},     64'(bus.done),     64'd0);
    chk({tag, "_fib_out"},  64'(bus.fib_out),  64'd0);
    chk({tag, "_fib_next"}, 64'(bus.fib_next), 64'd0);
    chk({tag, "_overflow"}, 64'(bus.overflow), 64'd0);
  endtask

  initial begin
    ref_f[0]  = '0;
    ref_f[1]  = OUT_W'(1);
    ref_ex[0] = 0;
    ref_ex[1] = 1;
    for (int i = 2; i < NREF; i++) begin
      ref_f[i]  = ref_f[i-1] + ref_f[i-2];
      ref_ex[i] = ref_ex[i-1] + ref_ex[i-2];
      if (ref_ex[i] > (64'd1 << 40)) ref_ex[i] = 64'd1 << 40;
    end
    for (int i = 0; i < NREF; i++) ref_ovf[i] = (ref_ex[i] >= (64'd1 << OUT_W));

    bus.start = 1'b0;
    bus.n_in  = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed corner values.
    issue(0);
    issue(1);
    issue(10);
    issue(24);
    issue(25);

    // Start while busy is ignored; next request lands in the done cycle.
    issue(10);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.n_in  = IN_W'(20);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    issue(20);

    // Reset mid-computation.
    issue(24);
    repeat (8) @(negedge clk);
    rst = 1'b0;
    sb.delete();
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (LAT + 5) @(negedge clk);
    @(posedge clk);
    #1;
    issue(2);

    // Full sweep with random idle gaps, then random indices.
    for (int n = 0; n < (1 << IN_W); n++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(posedge clk);
      issue(n);
    end
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 8)) @(posedge clk);
      issue(int'($urandom_range(0, (1 << IN_W) - 1)));
    end

    begin
      int w = 0;
      while (sb.size() > 0 && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (sb.size() > 0) begin
        checks++;
        failures++;
        $display("FAIL drain_timeout actual=%0d required=0 pending", sb.size());
      end
    end
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
